// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory stage: load func3 encodings, store masks, FSM states.
// MEM_MISALIGN_TRAP_EN adds the alignment-check helper used by the trap path.
package cpu_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] DWE_NONE = 4'b0000;
  localparam logic [3:0] DWE_SB   = 4'b0001;
  localparam logic [3:0] DWE_SH   = 4'b0011;
  localparam logic [3:0] DWE_SW   = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mau_state_e;

`ifdef MEM_MISALIGN_TRAP_EN
  // Any func3 that is not a byte or half access is handled as a word access.
  function automatic logic is_misaligned(input logic is_load, input logic [3:0] dwe,
                                         input logic [2:0] func3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (is_load) begin
      case (func3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = off[0];
        default:       bad = (off != 2'b00);
      endcase
    end else begin
      case (dwe)
        DWE_SH:  bad = off[0];
        DWE_SW:  bad = (off != 2'b00);
        default: bad = 1'b0;
      endcase
    end
    return bad;
  endfunction
`endif

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port of the memory stage.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req_out;
  logic [3:0]        dmem_we_out;
  logic [ADDR_W-1:0] dmem_addr_out;
  logic [31:0]       dmem_wdata_out;
  logic              dmem_ack_in;
  logic [31:0]       dmem_rdata_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
    input  dmem_ack_in, dmem_rdata_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
    output dmem_ack_in, dmem_rdata_in
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
module load_align
  import cpu_mem_pkg::*;
(
  input  logic [31:0] rdata_in,
  input  logic [1:0]  off_in,
  input  logic [2:0]  func3_in,
  output logic [31:0] data_out
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    byte_sh = rdata_in >> {off_in, 3'b000};
    half_sh = rdata_in >> {off_in[1], 4'b0000};
    case (func3_in)
      F3_LB:   data_out = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_LH:   data_out = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_LBU:  data_out = {24'h0, byte_sh[7:0]};
      F3_LHU:  data_out = {16'h0, half_sh[15:0]};
      default: data_out = rdata_in;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory pipeline stage: IDLE/REQ FSM driving a req/ack data port, store lane steering, MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_valid_in,
  input  logic [31:0]        mem_alu_out_in,
  input  logic [31:0]        mem_rv2_in,
  input  logic [3:0]         mem_dwe_in,
  input  logic [2:0]         mem_func3_in,
  input  logic               mem_mem_reg_in,
  input  logic               mem_reg_wr_in,
  input  logic [RD_W-1:0]    mem_rd_in,
  input  logic [1:0]         mem_reg_in_sel_in,
  input  logic [31:0]        mem_pc_imm_in,
  input  logic [31:0]        mem_imm_in,
  output logic               mem_stall_out,
  mem_access_unit_if.master  dmem,
  output logic               wb_valid_out,
  output logic [RD_W-1:0]    wb_rd_out,
  output logic               wb_reg_wr_out,
  output logic [1:0]         wb_reg_in_sel_out,
  output logic [31:0]        wb_load_data_out,
  output logic [31:0]        wb_alu_out_out,
  output logic [31:0]        wb_pc_imm_out,
  output logic [31:0]        wb_imm_out
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic               mem_misalign_out,
  output logic [31:0]        mem_bad_addr_out
`endif
);

  mau_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  // Accepted instruction, held while the access is outstanding since upstream moves on at accept.
  logic [RD_W-1:0]   p_rd_q, p_rd_d;
  logic              p_reg_wr_q, p_reg_wr_d;
  logic [1:0]        p_sel_q, p_sel_d;
  logic [31:0]       p_alu_q, p_alu_d;
  logic [31:0]       p_pc_imm_q, p_pc_imm_d;
  logic [31:0]       p_imm_q, p_imm_d;
  logic [2:0]        p_func3_q, p_func3_d;
  logic [1:0]        p_off_q, p_off_d;
  logic              p_load_q, p_load_d;

  logic              wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic              wb_reg_wr_q, wb_reg_wr_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic [31:0]       wb_load_q, wb_load_d;
  logic [31:0]       wb_alu_q, wb_alu_d;
  logic [31:0]       wb_pc_imm_q, wb_pc_imm_d;
  logic [31:0]       wb_imm_q, wb_imm_d;

`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign_q, misalign_d;
  logic [31:0]       bad_addr_q, bad_addr_d;
`endif

  logic              accept;
  logic              is_mem;
  logic [1:0]        off;
  logic [31:0]       lane_wdata;
  logic [31:0]       load_data;

  assign off = mem_alu_out_in[1:0];

  // Each byte lane picks its source so the data lines up with whichever lane the mask lands on.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (mem_dwe_in)
          DWE_SB:  lane_wdata[8*gi +: 8] = mem_rv2_in[7:0];
          DWE_SH:  lane_wdata[8*gi +: 8] = mem_rv2_in[8*(gi%2) +: 8];
          default: lane_wdata[8*gi +: 8] = mem_rv2_in[8*gi +: 8];
        endcase
      end
    end
  endgenerate

  load_align u_load_align (
    .rdata_in (dmem.dmem_rdata_in),
    .off_in   (p_off_q),
    .func3_in (p_func3_q),
    .data_out (load_data)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    p_rd_d      = p_rd_q;
    p_reg_wr_d  = p_reg_wr_q;
    p_sel_d     = p_sel_q;
    p_alu_d     = p_alu_q;
    p_pc_imm_d  = p_pc_imm_q;
    p_imm_d     = p_imm_q;
    p_func3_d   = p_func3_q;
    p_off_d     = p_off_q;
    p_load_d    = p_load_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_reg_wr_d = wb_reg_wr_q;
    wb_sel_d    = wb_sel_q;
    wb_load_d   = wb_load_q;
    wb_alu_d    = wb_alu_q;
    wb_pc_imm_d = wb_pc_imm_q;
    wb_imm_d    = wb_imm_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
    bad_addr_d  = bad_addr_q;
`endif

    accept = mem_valid_in && (state_q == ST_IDLE);
    is_mem = mem_mem_reg_in || (mem_dwe_in != DWE_NONE);

    if (accept) begin
      if (!is_mem) begin
        wb_valid_d  = 1'b1;
        wb_rd_d     = mem_rd_in;
        wb_reg_wr_d = mem_reg_wr_in;
        wb_sel_d    = mem_reg_in_sel_in;
        wb_alu_d    = mem_alu_out_in;
        wb_pc_imm_d = mem_pc_imm_in;
        wb_imm_d    = mem_imm_in;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      else if (is_misaligned(mem_mem_reg_in, mem_dwe_in, mem_func3_in, off)) begin
        wb_valid_d  = 1'b1;
        wb_rd_d     = mem_rd_in;
        wb_reg_wr_d = 1'b0;
        wb_sel_d    = mem_reg_in_sel_in;
        wb_alu_d    = mem_alu_out_in;
        wb_pc_imm_d = mem_pc_imm_in;
        wb_imm_d    = mem_imm_in;
        misalign_d  = 1'b1;
        bad_addr_d  = mem_alu_out_in;
      end
`endif
      else begin
        state_d    = ST_REQ;
        req_d      = 1'b1;
        we_d       = mem_mem_reg_in ? DWE_NONE : 4'(mem_dwe_in << off);
        addr_d     = {mem_alu_out_in[ADDR_W-1:2], 2'b00};
        wdata_d    = lane_wdata;
        p_rd_d     = mem_rd_in;
        p_reg_wr_d = mem_reg_wr_in;
        p_sel_d    = mem_reg_in_sel_in;
        p_alu_d    = mem_alu_out_in;
        p_pc_imm_d = mem_pc_imm_in;
        p_imm_d    = mem_imm_in;
        p_func3_d  = mem_func3_in;
        p_off_d    = off;
        p_load_d   = mem_mem_reg_in;
      end
    end else if ((state_q == ST_REQ) && dmem.dmem_ack_in) begin
      state_d     = ST_IDLE;
      req_d       = 1'b0;
      we_d        = DWE_NONE;
      wb_valid_d  = 1'b1;
      wb_rd_d     = p_rd_q;
      wb_reg_wr_d = p_reg_wr_q;
      wb_sel_d    = p_sel_q;
      wb_alu_d    = p_alu_q;
      wb_pc_imm_d = p_pc_imm_q;
      wb_imm_d    = p_imm_q;
      if (p_load_q) wb_load_d = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      p_rd_q      <= '0;
      p_reg_wr_q  <= 1'b0;
      p_sel_q     <= '0;
      p_alu_q     <= '0;
      p_pc_imm_q  <= '0;
      p_imm_q     <= '0;
      p_func3_q   <= '0;
      p_off_q     <= '0;
      p_load_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_reg_wr_q <= 1'b0;
      wb_sel_q    <= '0;
      wb_load_q   <= '0;
      wb_alu_q    <= '0;
      wb_pc_imm_q <= '0;
      wb_imm_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
      bad_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      p_rd_q      <= p_rd_d;
      p_reg_wr_q  <= p_reg_wr_d;
      p_sel_q     <= p_sel_d;
      p_alu_q     <= p_alu_d;
      p_pc_imm_q  <= p_pc_imm_d;
      p_imm_q     <= p_imm_d;
      p_func3_q   <= p_func3_d;
      p_off_q     <= p_off_d;
      p_load_q    <= p_load_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_reg_wr_q <= wb_reg_wr_d;
      wb_sel_q    <= wb_sel_d;
      wb_load_q   <= wb_load_d;
      wb_alu_q    <= wb_alu_d;
      wb_pc_imm_q <= wb_pc_imm_d;
      wb_imm_q    <= wb_imm_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
      bad_addr_q  <= bad_addr_d;
`endif
    end
  end

  assign mem_stall_out       = (state_q == ST_REQ);
  assign dmem.dmem_req_out   = req_q;
  assign dmem.dmem_we_out    = we_q;
  assign dmem.dmem_addr_out  = addr_q;
  assign dmem.dmem_wdata_out = wdata_q;
  assign wb_valid_out        = wb_valid_q;
  assign wb_rd_out           = wb_rd_q;
  assign wb_reg_wr_out       = wb_reg_wr_q;
  assign wb_reg_in_sel_out   = wb_sel_q;
  assign wb_load_data_out    = wb_load_q;
  assign wb_alu_out_out      = wb_alu_q;
  assign wb_pc_imm_out       = wb_pc_imm_q;
  assign wb_imm_out          = wb_imm_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mem_misalign_out    = misalign_q;
  assign mem_bad_addr_out    = bad_addr_q;
`endif

endmodule
